// File: rtl/cc_line_serializer_p.sv
// Purpose : cache-line to beat serializer on the read-return path; pops one line from a show-ahead FIFO.
// Latency : first beat one cycle after the pop; back-to-back lines stream with no bubble.
// Backpr. : full valid/ready back-pressure; beat data, id and last hold while rvalid_o & !rready_i.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   fifo_empty_i          FIFO empty; fifo_line_i/ofs/wrap/id are valid whenever this is low
//   fifo_line_i           line data, beat k at [k*BEAT_W +: BEAT_W]
//   fifo_ofs_i            first beat index of the burst
//   fifo_wrap_i           1 = wrap burst (all beats), 0 = incrementing burst (ofs..BEATS-1)
//   fifo_id_i             transaction id
//   fifo_rden_o           pop strobe, one cycle per line (combinational)
//   rdata_o/rid_o/rlast_o beat data, id and last flag of the current beat
//   rvalid_o/rready_i     read-channel handshake
//   busy_o                high while a line is being sent
module cc_line_serializer_p #(
   parameter  int LINE_W = 512,
   parameter  int BEAT_W = 64,
   parameter  int ID_W   = 4,
   localparam int BEATS  = LINE_W / BEAT_W,
   localparam int OFS_W  = $clog2(BEATS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty_i,
   input  logic [LINE_W-1:0] fifo_line_i,
   input  logic [OFS_W-1:0]  fifo_ofs_i,
   input  logic              fifo_wrap_i,
   input  logic [ID_W-1:0]   fifo_id_i,
   output logic              fifo_rden_o,
   output logic [BEAT_W-1:0] rdata_o,
   output logic [ID_W-1:0]   rid_o,
   output logic              rlast_o,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic              busy_o
);

   if ((LINE_W % BEAT_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_cfg
      $error("cc_line_serializer_p: LINE_W/BEAT_W must be an integer power of two >= 2");
   end

   localparam logic S_IDLE = 1'b0;
   localparam logic S_SEND = 1'b1;

   localparam logic [OFS_W-1:0] CNT_MAX = '1;

   logic                         r_state;
   logic [OFS_W-1:0]             r_cnt;
   logic [BEATS-1:0][BEAT_W-1:0] r_line;
   logic [OFS_W-1:0]             r_ofs;
   logic                         r_wrap;
   logic [ID_W-1:0]              r_id;

   logic                         w_send;
   logic [OFS_W-1:0]             w_idx;
   logic [OFS_W:0]               w_sum;
   logic                         w_last;
   logic                         w_xfer;
   logic                         w_last_xfer;
   logic                         w_pop;

   assign w_send = (r_state == S_SEND);

   // Wrap bursts rotate through the line with a natural OFS_W-bit wrap.
   assign w_idx  = r_ofs + r_cnt;

   // Incrementing bursts end at the top beat, so the sum is taken one bit wider
   // to avoid matching after a wrap.
   assign w_sum  = {1'b0, r_ofs} + {1'b0, r_cnt};
   assign w_last = r_wrap ? (r_cnt == CNT_MAX) : (w_sum == {1'b0, CNT_MAX});

   assign w_xfer      = w_send & rready_i;
   assign w_last_xfer = w_xfer & w_last;

   // Pop when idle, or on the last beat so the next line follows without a bubble.
   // Held off during reset so a line presented while in reset is not lost.
   assign w_pop = rst_n & ~fifo_empty_i & (~w_send | w_last_xfer);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_line  <= '0;
         r_ofs   <= '0;
         r_wrap  <= 1'b0;
         r_id    <= '0;
      end else if (w_pop) begin
         r_state <= S_SEND;
         r_cnt   <= '0;
         r_line  <= fifo_line_i;
         r_ofs   <= fifo_ofs_i;
         r_wrap  <= fifo_wrap_i;
         r_id    <= fifo_id_i;
      end else if (w_last_xfer) begin
         r_state <= S_IDLE;
      end else if (w_xfer) begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign fifo_rden_o = w_pop;
   assign rvalid_o    = w_send;
   assign busy_o      = w_send;
   assign rlast_o     = w_send & w_last;
   assign rdata_o     = r_line[w_idx];
   assign rid_o       = r_id;

endmodule
